// File: rtl/echo_request_deser_pkg.sv
// rtl/echo_request_deser_pkg.sv - shared constants, header fields and state encoding for the EchoRequest path
package rulec_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MSG_WORDS  = 4;
    localparam int OUT_WIDTH  = DATA_WIDTH * MSG_WORDS;

    localparam int HDR_METH_HI = 31;
    localparam int HDR_METH_LO = 16;
    localparam int HDR_LEN_HI  = 15;
    localparam int HDR_LEN_LO  = 0;

    typedef enum logic [1:0] {
        ST_HDR,
        ST_BODY,
        ST_DRAIN,
        ST_DELIVER
    } state_e;

    // Method numbers shared with the downstream demultiplexer
    localparam logic [15:0] METH_SAY2    = 16'd0;
    localparam logic [15:0] METH_SAY     = 16'd1;
    localparam logic [15:0] METH_SETLEDS = 16'd2;

    function automatic logic [15:0] hdr_len(input logic [DATA_WIDTH-1:0] w);
        return w[HDR_LEN_HI:HDR_LEN_LO];
    endfunction

endpackage

// File: rtl/echo_request_deser_if.sv
// rtl/echo_request_deser_if.sv - word input, packed-message output and error count of the deserialiser
interface echo_request_deser_if;
    import rulec_pkg::*;

    logic                  in_enq_ena;
    logic [DATA_WIDTH-1:0] in_enq_v;
    logic                  in_enq_rdy;
    logic                  pipe_enq_ena;
    logic [OUT_WIDTH-1:0]  pipe_enq_v;
    logic                  pipe_enq_rdy;
    logic [7:0]            err_count;

    modport slave (
        input  in_enq_ena, in_enq_v, pipe_enq_rdy,
        output in_enq_rdy, pipe_enq_ena, pipe_enq_v, err_count
    );

    modport master (
        output in_enq_ena, in_enq_v, pipe_enq_rdy,
        input  in_enq_rdy, pipe_enq_ena, pipe_enq_v, err_count
    );

endinterface

// File: rtl/echo_request_deser.sv
// rtl/echo_request_deser.sv - packs a header-framed stream of 32-bit words into one 128-bit message
module echo_request_deser
    import rulec_pkg::*;
(
    input  logic                CLK,
    input  logic                nRST,
    echo_request_deser_if.slave bus
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] buf_q [MSG_WORDS];
    logic [DATA_WIDTH-1:0] buf_d [MSG_WORDS];
    logic [1:0]            idx_q, idx_d;
    logic                  ovf_q, ovf_d;
    logic [15:0]           rem_q, rem_d;
    logic [7:0]            err_q, err_d;
    logic                  err_inc;
    logic                  pipe_ena;
    logic [15:0]           len;
    logic [15:0]           rem_dec;

    assign len     = hdr_len(bus.in_enq_v);
    assign rem_dec = rem_q - 16'd1;

    always_comb begin
        state_d  = state_q;
        buf_d    = buf_q;
        idx_d    = idx_q;
        ovf_d    = ovf_q;
        rem_d    = rem_q;
        err_inc  = 1'b0;
        pipe_ena = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (bus.in_enq_ena) begin
                    buf_d[0] = bus.in_enq_v;
                    for (int k = 1; k < MSG_WORDS; k++) buf_d[k] = '0;
                    idx_d = 2'd1;
                    ovf_d = 1'b0;
                    if (len <= 16'd1) begin
                        rem_d   = 16'd0;
                        err_inc = (len == 16'd0);
                        state_d = ST_DELIVER;
                    end else begin
                        rem_d   = len - 16'd1;
                        state_d = ST_BODY;
                    end
                end
            end
            ST_BODY: begin
                if (bus.in_enq_ena) begin
                    if (!ovf_q) buf_d[idx_q] = bus.in_enq_v;
                    {ovf_d, idx_d} = {1'b0, idx_q} + 3'd1;
                    rem_d = rem_dec;
                    if (rem_dec == 16'd0) begin
                        state_d = ST_DELIVER;
                    end else if (idx_q == 2'd3) begin
                        // Buffer full but the header promised more: count once, then discard the rest
                        err_inc = 1'b1;
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (bus.in_enq_ena) begin
                    rem_d = rem_dec;
                    if (rem_dec == 16'd0) state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                pipe_ena = bus.pipe_enq_rdy;
                if (bus.pipe_enq_rdy) state_d = ST_HDR;
            end
            default: state_d = ST_HDR;
        endcase
        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
    end

    always_ff @(posedge CLK or posedge nRST) begin
        if (nRST) begin
            state_q <= ST_HDR;
            for (int k = 0; k < MSG_WORDS; k++) buf_q[k] <= '0;
            idx_q   <= 2'd0;
            ovf_q   <= 1'b0;
            rem_q   <= 16'd0;
            err_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            for (int k = 0; k < MSG_WORDS; k++) buf_q[k] <= buf_d[k];
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    assign bus.in_enq_rdy   = (state_q != ST_DELIVER);
    assign bus.pipe_enq_ena = pipe_ena;
    assign bus.pipe_enq_v   = {buf_q[3], buf_q[2], buf_q[1], buf_q[0]};
    assign bus.err_count    = err_q;

endmodule

// File: tb/tb_echo_request_deser.sv
// tb/tb_echo_request_deser.sv - randomized scoreboard bench for echo_request_deser
module tb_echo_request_deser;
    import rulec_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    echo_request_deser_if bus ();

    echo_request_deser dut (
        .CLK  (clk),
        .nRST (rst),
        .bus  (bus)
    );

    int errors = 0;
    int checks = 0;
    int model_err = 0;
    int n_deliv = 0;
    logic [127:0] exp_data_q [$];
    logic [7:0]   exp_err_q  [$];
    bit rand_bp   = 1'b0;
    bit force_rdy = 1'b1;
    logic [31:0] pl [7];

    always begin
        bus.pipe_enq_rdy = rand_bp ? ($urandom_range(0, 3) != 0) : force_rdy;
        @(posedge clk);
        #1;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic put_word(input logic [31:0] w, input bit gaps);
        int guard;
        @(posedge clk);
        #1;
        if (gaps && $urandom_range(0, 3) == 0) begin
            bus.in_enq_ena = 1'b0;
            @(posedge clk);
            #1;
        end
        guard = 0;
        while (bus.in_enq_rdy !== 1'b1) begin
            bus.in_enq_ena = 1'b0;
            @(posedge clk);
            #1;
            guard++;
            if (guard > 1000) begin
                check("in_rdy_timeout", 128'd0, 128'd1);
                break;
            end
        end
        bus.in_enq_ena = 1'b1;
        bus.in_enq_v   = w;
    endtask

    task automatic end_words();
        @(posedge clk);
        #1;
        bus.in_enq_ena = 1'b0;
    endtask

    // Reference: slot 0 = header, then up to three payload words; lengths 0 or >4 are errors
    task automatic send_msg(input logic [31:0] hdr, input logic [31:0] p [7], input bit gaps);
        int len;
        int eff;
        int n;
        logic [127:0] d;
        len = int'(hdr[15:0]);
        eff = (len == 0) ? 1 : len;
        n   = (eff < 4) ? eff : 4;
        d   = '0;
        d[31:0] = hdr;
        for (int k = 1; k < n; k++) d[32*k +: 32] = p[k-1];
        if (len == 0 || len > 4) model_err = (model_err < 255) ? model_err + 1 : 255;
        exp_data_q.push_back(d);
        exp_err_q.push_back(model_err[7:0]);
        put_word(hdr, gaps);
        for (int k = 0; k < eff - 1; k++) put_word(p[k], gaps);
        end_words();
    endtask

    task automatic wait_drain();
        int g;
        g = 0;
        while (exp_data_q.size() != 0 && g < 3000) begin
            @(posedge clk);
            g++;
        end
        check("drain", 128'(exp_data_q.size()), 128'd0);
    endtask

    initial begin
        int n0;
        logic [127:0] held;
        logic [31:0] hdr;

        bus.in_enq_ena = 1'b0;
        bus.in_enq_v   = '0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && bus.pipe_enq_ena === 1'b1) begin
                    n_deliv++;
                    if (exp_data_q.size() == 0) begin
                        check("unexpected_delivery", 128'd1, 128'd0);
                    end else begin
                        check("deliver_data", bus.pipe_enq_v, exp_data_q.pop_front());
                        check("deliver_err", 128'(bus.err_count), 128'(exp_err_q.pop_front()));
                    end
                end
            end
        join_none

        #1;
        check("rst_in_rdy", 128'(bus.in_enq_rdy), 128'd1);
        check("rst_pipe_ena", 128'(bus.pipe_enq_ena), 128'd0);
        check("rst_pipe_v", bus.pipe_enq_v, 128'd0);
        check("rst_err", 128'(bus.err_count), 128'd0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Two-word say message, latency two cycles after the header
        pl[0] = 32'h1234_5678;
        send_msg(32'h0001_0002, pl, 1'b0);
        @(negedge clk);
        check("lat2_ena", 128'(bus.pipe_enq_ena), 128'd1);
        check("lat2_in_rdy", 128'(bus.in_enq_rdy), 128'd0);
        check("lat2_data", bus.pipe_enq_v, {64'h0, 32'h1234_5678, 32'h0001_0002});
        wait_drain();

        // Backpressure hold
        force_rdy = 1'b0;
        repeat (2) @(posedge clk);
        pl[0] = 32'h0007_0005;
        send_msg(32'h0000_0002, pl, 1'b0);
        held = {64'h0, 32'h0007_0005, 32'h0000_0002};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_in_rdy", 128'(bus.in_enq_rdy), 128'd0);
            check("bp_ena", 128'(bus.pipe_enq_ena), 128'd0);
            check("bp_data", bus.pipe_enq_v, held);
        end
        n0 = n_deliv;
        force_rdy = 1'b1;
        repeat (6) @(posedge clk);
        check("bp_one_pulse", 128'(n_deliv - n0), 128'd1);
        wait_drain();

        // Over-length message truncated to four words
        for (int k = 0; k < 7; k++) pl[k] = 32'(k + 1);
        send_msg(32'h0002_0006, pl, 1'b0);
        wait_drain();
        check("overlen_err", 128'(bus.err_count), 128'd1);

        // Length zero delivers the header alone immediately
        send_msg(32'h0001_0000, pl, 1'b0);
        @(negedge clk);
        check("len0_ena", 128'(bus.pipe_enq_ena), 128'd1);
        wait_drain();
        check("len0_err", 128'(bus.err_count), 128'd2);

        // Reset mid-message: partial message discarded
        n0 = n_deliv;
        put_word(32'h0003_0004, 1'b0);
        put_word(32'hDEAD_BEEF, 1'b0);
        @(posedge clk);
        #1;
        bus.in_enq_ena = 1'b0;
        #2;
        rst = 1'b1;
        model_err = 0;
        #1;
        check("arst_in_rdy", 128'(bus.in_enq_rdy), 128'd1);
        check("arst_pipe_ena", 128'(bus.pipe_enq_ena), 128'd0);
        check("arst_pipe_v", bus.pipe_enq_v, 128'd0);
        check("arst_err", 128'(bus.err_count), 128'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) @(posedge clk);
        check("arst_no_deliver", 128'(n_deliv - n0), 128'd0);
        pl[0] = 32'hCAFE_0001;
        send_msg(32'h0002_0002, pl, 1'b0);
        wait_drain();

        // Randomized messages with random gaps and backpressure
        rand_bp = 1'b1;
        for (int m = 0; m < 40; m++) begin
            hdr = {16'($urandom_range(0, 2)), 16'($urandom_range(0, 8))};
            for (int k = 0; k < 7; k++) pl[k] = $urandom;
            send_msg(hdr, pl, 1'b1);
        end
        wait_drain();
        rand_bp = 1'b0;

        // Error counter saturation
        for (int m = 0; m < 300; m++) begin
            hdr = {16'($urandom_range(0, 2)), 16'h0000};
            send_msg(hdr, pl, 1'b0);
        end
        wait_drain();
        check("sat_err", 128'(bus.err_count), 128'd255);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
